multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Moore-style main control FSM for the multi-cycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback
//  per opcode and drives datapath selects. Emits the 2-bit ALUop consumed by alu_control
//  (00 add, 01 sub, 10 R-type via func, 11 sub for bgtz). Stalls on memory via mem_ready; counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  opcode       in   6      IR[31:26], stable from end of FETCH until next FETCH
//  zero         in   1      ALU zero flag
//  alu_neg      in   1      ALU result bit 31
//  mem_ready    in   1      memory access completes this cycle
//  pc_write     out  1      PC load enable (unconditional OR taken branch)
//  iord         out  1      0 = PC addresses memory, 1 = ALUOut
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  ir_write     out  1      IR load enable
//  reg_dst      out  1      0 = rt, 1 = rd
//  mem_to_reg   out  1      0 = ALUOut, 1 = MDR
//  reg_write    out  1      register file write enable
//  alu_src_a    out  1      0 = PC, 1 = A
//  alu_src_b    out  2      00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  alu_op       out  2      to alu_control
//  pc_source    out  2      00 = ALU result, 01 = ALUOut, 10 = jump target
//  state        out  4      current state encoding (debug)
//  illegal_op   out  1      1-cycle flag: unknown opcode in DECODE
//  instr_count  out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
//  Reset:
//   - state = FETCH(0), instr_count = 0.
//   - While reset is high, all control outputs are forced to 0.
//   - Reset mid-instruction aborts the instruction without a count.
//  Outputs not listed for a state are 0.
//  Opcodes: R 000000, lw 100011, sw 101011, addi 001000, beq 000100, bne 000101, bgtz 000111, j 000010.
//  0 FETCH
//   - mem_read = 1, src_a = 0, src_b = 01, op = 00.
//   - ir_write and pc_write are asserted only when mem_ready = 1, then go to DECODE; otherwise hold in FETCH.
//  1 DECODE
//   - src_a = 0, src_b = 11, op = 00 (branch target into ALUOut).
//   - Next state: lw/sw -> 2, R -> 6, branches -> 8, j -> 9, addi -> 10.
//   - Any other opcode: illegal_op = 1 this cycle, next FETCH, no count.
//  2 MEMADR
//   - src_a = 1, src_b = 10, op = 00.
//   - Next: lw -> 3, sw -> 5.
//  3 MEMRD
//   - mem_read = 1, iord = 1.
//   - Go to 4 when mem_ready = 1, else hold.
//  4 MEMWB
//   - reg_write = 1, mem_to_reg = 1, reg_dst = 0.
//   - Go to FETCH.
//  5 MEMWR
//   - mem_write = 1, iord = 1.
//   - Go to FETCH when mem_ready = 1, else hold (mem_write stays high).
//  6 EXEC
//   - src_a = 1, src_b = 00, op = 10.
//   - Go to 7.
//  7 RWB
//   - reg_write = 1, reg_dst = 1, mem_to_reg = 0.
//   - Go to FETCH.
//  8 BRANCH
//   - src_a = 1, src_b = 00, pc_source = 01.
//   - op = 11 for bgtz, 01 otherwise.
//   - pc_write = taken, where taken is: beq: zero; bne: !zero; bgtz: !zero & !alu_neg.
//   - Go to FETCH.
//  9 JUMP
//   - pc_source = 10, pc_write = 1.
//   - Go to FETCH.
//  10 ADDI_EX
//   - src_a = 1, src_b = 10, op = 00.
//   - Go to 11.
//  11 ADDI_WB
//   - reg_write = 1, reg_dst = 0, mem_to_reg = 0.
//   - Go to FETCH.
//  Encodings 12-15: go to FETCH next cycle, all outputs 0.
//  Outputs:
//   - All outputs are combinational from state.
//   - pc_write, ir_write and FETCH/MEMRD/MEMWR advance also depend on zero, alu_neg and mem_ready.
//  instr_count:
//   - Increments by 1 on the edge leaving 4, 7, 8, 9 or 11.
//   - Also increments on the edge leaving 5 with mem_ready = 1.
//   - Wraps modulo 2^CNT_W.
//  Per-instruction cycle counts (mem_ready always 1):
//   - lw 5, sw 4, R 4, addi 4, branch 3, j 3.
//   - Each mem_ready = 0 cycle adds 1.
// TESTING
//  1 R-type (opcode 0), mem_ready = 1:
//    - state 0,1,6,7,0.
//    - alu_op 10 in EXEC.
//    - reg_write = 1 and reg_dst = 1 in RWB.
//    - instr_count 0 -> 1.
//  2 lw with mem_ready low 3 cycles in MEMRD:
//    - MEMRD held 4 cycles with mem_read = 1, iord = 1.
//    - Then MEMWB with mem_to_reg = 1; 8 cycles total.
//  3 beq:
//    - zero = 1 -> pc_write = 1 in BRANCH, alu_op = 01.
//    - zero = 0 -> pc_write = 0.
//    - bgtz with zero = 0, alu_neg = 0 -> pc_write = 1, alu_op = 11.
//  4 opcode 111111:
//    - illegal_op pulses 1 cycle in DECODE, then FETCH.
//    - instr_count unchanged.
//  5 Reset asserted during MEMWR:
//    - Outputs go to 0 immediately; state = 0 and count = 0.
//    - After release, FETCH resumes with mem_read = 1.
//  6 CNT_W = 4, 16 j instructions:
//    - instr_count wraps to 0.
//    - pc_source = 10 and pc_write = 1 in each JUMP.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// It sequences fetch, decode, execute, memory and writeback for each opcode and drives
// the datapath selects. It also counts retired instructions.
// Outputs are combinational from the current state. pc_write, ir_write and the memory-wait
// transitions also look at zero, alu_neg and mem_ready.
module multicycle_main_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             alu_neg_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_op_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpBgtz  = 6'b000111;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q;
  logic             retire;
  logic             taken;

  // Branch condition for the opcode currently held in IR.
  always_comb begin
    taken = 1'b0;
    case (opcode_i)
      OpBeq:   taken = zero_i;
      OpBne:   taken = ~zero_i;
      OpBgtz:  taken = ~zero_i & ~alu_neg_i;
      default: taken = 1'b0;
    endcase
  end

  // Next-state selection and retirement detection.
  always_comb begin
    state_d = StFetch;
    retire  = 1'b0;
    case (state_q)
      StFetch:  state_d = mem_ready_i ? StDecode : StFetch;
      StDecode: begin
        case (opcode_i)
          OpLw, OpSw:            state_d = StMemAdr;
          OpRtype:               state_d = StExec;
          OpBeq, OpBne, OpBgtz:  state_d = StBranch;
          OpJ:                   state_d = StJump;
          OpAddi:                state_d = StAddiEx;
          default:               state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        if (opcode_i == OpLw) begin
          state_d = StMemRd;
        end else if (opcode_i == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd:  state_d = mem_ready_i ? StMemWb : StMemRd;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        state_d = mem_ready_i ? StFetch : StMemWr;
        retire  = mem_ready_i;
      end
      StExec:   state_d = StRwb;
      StRwb, StBranch, StJump, StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  // Moore-style outputs, forced low while reset is asserted.
  always_comb begin
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_source_o  = 2'b00;
    illegal_op_o = 1'b0;
    if (!reset_i) begin
      case (state_q)
        StFetch: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        StDecode: begin
          // Precompute the branch target into ALUOut.
          alu_src_b_o = 2'b11;
          case (opcode_i)
            OpRtype, OpLw, OpSw, OpAddi, OpBeq, OpBne, OpBgtz, OpJ: illegal_op_o = 1'b0;
            default:                                                 illegal_op_o = 1'b1;
          endcase
        end
        StMemAdr, StAddiEx: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        StMemRd: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        StMemWb: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        StMemWr: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        StExec: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 2'b10;
        end
        StRwb: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        StBranch: begin
          alu_src_a_o = 1'b1;
          pc_source_o = 2'b01;
          alu_op_o    = (opcode_i == OpBgtz) ? 2'b11 : 2'b01;
          pc_write_o  = taken;
        end
        StJump: begin
          pc_source_o = 2'b10;
          pc_write_o  = 1'b1;
        end
        StAddiWb: reg_write_o = 1'b1;
        default: ;
      endcase
    end
  end

  // State register and retired-instruction counter; reset aborts without counting.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StFetch;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_count_q <= instr_count_q + CNT_W'(1);
      end
    end
  end

  assign state_o       = state_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control.
// The stimulus process drives one cycle at a time and queues the hand-computed response.
// A monitor pops the queue on each falling edge and compares. A second instance with
// CNT_W = 4 shares the inputs, so the counter wrap can be checked.
module tb_multicycle_main_control;

  logic clk, reset;
  logic [5:0] opcode;
  logic zero, alu_neg, mem_ready;

  logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic illegal_op;
  logic [31:0] instr_count;

  logic pc_write4, iord4, mem_read4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4;
  logic alu_src_a4;
  logic [1:0] alu_src_b4, alu_op4, pc_source4;
  logic [3:0] state4;
  logic illegal_op4;
  logic [3:0] instr_count4;

  multicycle_main_control dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero), .alu_neg_i(alu_neg),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write), .iord_o(iord), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .ir_write_o(ir_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_source_o(pc_source), .state_o(state),
    .illegal_op_o(illegal_op), .instr_count_o(instr_count)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero), .alu_neg_i(alu_neg),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write4), .iord_o(iord4), .mem_read_o(mem_read4),
    .mem_write_o(mem_write4), .ir_write_o(ir_write4), .reg_dst_o(reg_dst4),
    .mem_to_reg_o(mem_to_reg4), .reg_write_o(reg_write4), .alu_src_a_o(alu_src_a4),
    .alu_src_b_o(alu_src_b4), .alu_op_o(alu_op4), .pc_source_o(pc_source4), .state_o(state4),
    .illegal_op_o(illegal_op4), .instr_count_o(instr_count4)
  );

  // Packed control word: pw iord mr mw irw rdst m2r rw srca srcb op pcsrc
  logic [14:0] ctl, ctl4;
  assign ctl  = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, alu_op, pc_source};
  assign ctl4 = {pc_write4, iord4, mem_read4, mem_write4, ir_write4, reg_dst4, mem_to_reg4,
                 reg_write4, alu_src_a4, alu_src_b4, alu_op4, pc_source4};

  localparam logic [14:0] CZero   = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] CFetch  = 15'b1_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [14:0] CFWait  = 15'b0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] CDecode = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] CMemAdr = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] CMemRd  = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] CMemWb  = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [14:0] CMemWr  = 15'b0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [14:0] CExec   = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] CRwb    = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] CBrT    = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] CBrNT   = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] CBgtT   = 15'b1_0_0_0_0_0_0_0_1_00_11_01;
  localparam logic [14:0] CBgtNT  = 15'b0_0_0_0_0_0_0_0_1_00_11_01;
  localparam logic [14:0] CJump   = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [14:0] CAddiEx = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] CAddiWb = 15'b0_0_0_0_0_0_0_1_0_00_00_00;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpAddi = 6'b001000, OpBeq = 6'b000100, OpBne = 6'b000101;
  localparam logic [5:0] OpBgtz = 6'b000111, OpJ = 6'b000010, OpBad = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", {28'd0, state}, {28'd0, e.st});
      chk("ctl", {17'd0, ctl}, {17'd0, e.ctl});
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
      chk("instr_count", instr_count, e.cnt);
      chk("state_w4", {28'd0, state4}, {28'd0, e.st});
      chk("ctl_w4", {17'd0, ctl4}, {17'd0, e.ctl});
      chk("instr_count_w4", {28'd0, instr_count4}, {28'd0, e.cnt[3:0]});
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue its expected response.
  task automatic step(input logic [5:0] op, input logic z, input logic n, input logic mr,
                      input logic rs, input logic [3:0] st, input logic [14:0] c,
                      input logic ill, input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; zero = z; alu_neg = n; mem_ready = mr; reset = rs;
    e.st = st; e.ctl = c; e.ill = ill; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = OpR; zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b0;
    // Reset held: outputs all zero.
    step(OpR, 0, 0, 0, 1, 4'd0, CZero, 0, 0);
    // R-type.
    step(OpR, 0, 0, 1, 0, 4'd0, CFetch, 0, 0);
    step(OpR, 0, 0, 1, 0, 4'd1, CDecode, 0, 0);
    step(OpR, 0, 0, 1, 0, 4'd6, CExec, 0, 0);
    step(OpR, 0, 0, 1, 0, 4'd7, CRwb, 0, 0);
    // lw with three wait cycles in MEMRD.
    step(OpLw, 0, 0, 1, 0, 4'd0, CFetch, 0, 1);
    step(OpLw, 0, 0, 1, 0, 4'd1, CDecode, 0, 1);
    step(OpLw, 0, 0, 1, 0, 4'd2, CMemAdr, 0, 1);
    for (int i = 0; i < 3; i++) step(OpLw, 0, 0, 0, 0, 4'd3, CMemRd, 0, 1);
    step(OpLw, 0, 0, 1, 0, 4'd3, CMemRd, 0, 1);
    step(OpLw, 0, 0, 1, 0, 4'd4, CMemWb, 0, 1);
    // beq taken.
    step(OpBeq, 1, 0, 1, 0, 4'd0, CFetch, 0, 2);
    step(OpBeq, 1, 0, 1, 0, 4'd1, CDecode, 0, 2);
    step(OpBeq, 1, 0, 1, 0, 4'd8, CBrT, 0, 2);
    // beq not taken.
    step(OpBeq, 0, 0, 1, 0, 4'd0, CFetch, 0, 3);
    step(OpBeq, 0, 0, 1, 0, 4'd1, CDecode, 0, 3);
    step(OpBeq, 0, 0, 1, 0, 4'd8, CBrNT, 0, 3);
    // bgtz taken.
    step(OpBgtz, 0, 0, 1, 0, 4'd0, CFetch, 0, 4);
    step(OpBgtz, 0, 0, 1, 0, 4'd1, CDecode, 0, 4);
    step(OpBgtz, 0, 0, 1, 0, 4'd8, CBgtT, 0, 4);
    // bne taken.
    step(OpBne, 0, 0, 1, 0, 4'd0, CFetch, 0, 5);
    step(OpBne, 0, 0, 1, 0, 4'd1, CDecode, 0, 5);
    step(OpBne, 0, 0, 1, 0, 4'd8, CBrT, 0, 5);
    // bgtz with a negative result is not taken.
    step(OpBgtz, 0, 1, 1, 0, 4'd0, CFetch, 0, 6);
    step(OpBgtz, 0, 1, 1, 0, 4'd1, CDecode, 0, 6);
    step(OpBgtz, 0, 1, 1, 0, 4'd8, CBgtNT, 0, 6);
    // sw with a fetch wait and a write wait.
    step(OpSw, 0, 0, 0, 0, 4'd0, CFWait, 0, 7);
    step(OpSw, 0, 0, 1, 0, 4'd0, CFetch, 0, 7);
    step(OpSw, 0, 0, 1, 0, 4'd1, CDecode, 0, 7);
    step(OpSw, 0, 0, 1, 0, 4'd2, CMemAdr, 0, 7);
    step(OpSw, 0, 0, 0, 0, 4'd5, CMemWr, 0, 7);
    step(OpSw, 0, 0, 1, 0, 4'd5, CMemWr, 0, 7);
    // addi.
    step(OpAddi, 0, 0, 1, 0, 4'd0, CFetch, 0, 8);
    step(OpAddi, 0, 0, 1, 0, 4'd1, CDecode, 0, 8);
    step(OpAddi, 0, 0, 1, 0, 4'd10, CAddiEx, 0, 8);
    step(OpAddi, 0, 0, 1, 0, 4'd11, CAddiWb, 0, 8);
    // Illegal opcode: one-cycle flag, no count.
    step(OpBad, 0, 0, 1, 0, 4'd0, CFetch, 0, 9);
    step(OpBad, 0, 0, 1, 0, 4'd1, CDecode, 1, 9);
    // j.
    step(OpJ, 0, 0, 1, 0, 4'd0, CFetch, 0, 9);
    step(OpJ, 0, 0, 1, 0, 4'd1, CDecode, 0, 9);
    step(OpJ, 0, 0, 1, 0, 4'd9, CJump, 0, 9);
    // sw interrupted by reset while waiting in MEMWR.
    step(OpSw, 0, 0, 1, 0, 4'd0, CFetch, 0, 10);
    step(OpSw, 0, 0, 1, 0, 4'd1, CDecode, 0, 10);
    step(OpSw, 0, 0, 1, 0, 4'd2, CMemAdr, 0, 10);
    step(OpSw, 0, 0, 0, 0, 4'd5, CMemWr, 0, 10);
    step(OpSw, 0, 0, 0, 1, 4'd0, CZero, 0, 0);
    step(OpSw, 0, 0, 1, 1, 4'd0, CZero, 0, 0);
    // Sixteen jumps from a cleared counter; the 4-bit instance wraps to 0.
    for (int i = 0; i < 16; i++) begin
      step(OpJ, 0, 0, 1, 0, 4'd0, CFetch, 0, 32'(i));
      step(OpJ, 0, 0, 1, 0, 4'd1, CDecode, 0, 32'(i));
      step(OpJ, 0, 0, 1, 0, 4'd9, CJump, 0, 32'(i));
    end
    step(OpR, 0, 0, 0, 0, 4'd0, CFWait, 0, 16);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
